// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial add/subtract sequencer. It drives a 1-bit adder cell (two
//   half-adder stages plus a carry flip-flop) over two WIDTH-bit operands,
//   LSB first, one bit per clock. The result, the carry out and the signed
//   overflow are presented with a one-cycle done pulse.
//
// Handshake: start is a request. It is accepted on any clk edge where the
//   block is in IDLE or DONE and start=1; a, b and sub are captured on that
//   same edge. While busy=1 (RUN), start, a, b and sub are ignored. done is
//   high for exactly one cycle when sum/carry/overflow have just been
//   updated. There is no backpressure: the result registers simply hold
//   until the next completion.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request (sampled in IDLE or DONE)
//   sub       0 = a+b, 1 = a-b (sampled with start)
//   a, b      WIDTH-bit operands (sampled with start)
//   busy      high while in RUN
//   done      one-cycle pulse when the result is valid
//   sum       WIDTH-bit result, held until the next completion
//   carry     carry out of the MSB (for sub, 1 = no borrow)
//   overflow  two's-complement overflow of the last operation
//   state_dbg current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // sa doubles as the result register: each bit cycle consumes sa[0] and
  // inserts the new sum bit at the MSB, so after WIDTH shifts it holds the
  // complete result in the right bit positions.
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             cff;
  logic             cprev;
  logic [CW-1:0]    cnt;

  // Adder cell and control strobes
  logic h, g, s, co;
  logic load, last;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    // Stage 1 half adder on the operand bits, stage 2 with the carry FF.
    h  = sa[0] ^ sb[0];
    g  = sa[0] & sb[0];
    s  = h ^ cff;
    co = g | (h & cff);
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa       <= '0;
      sb       <= '0;
      cff      <= 1'b0;
      cprev    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      sa  <= a;
      // Subtraction is a + ~b + 1: invert b and preload the carry with 1.
      sb  <= sub ? ~b : b;
      cff <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= {s, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      cff <= co;
      // Carry into the MSB, needed for the overflow rule on the last bit.
      if (cnt == PRE_CNT) begin
        cprev <= co;
      end
      if (last) begin
        sum      <= {s, sa[WIDTH-1:1]};
        carry    <= co;
        overflow <= co ^ cprev;
      end else begin
        // Hold the counter on the last bit so it never wraps.
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview: Sequencer that drives a 1-bit adder cell (two half-adder stages plus a carry flip-flop) to add or subtract two WIDTH-bit operands bit-serially, LSB first, one bit per clock. It sits beside the processor ALU as a low-area arithmetic path. It accepts a start/operand request, runs WIDTH bit-cycles, and then presents sum, carry and overflow with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2 to 32.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
sub  input  1  0 = a+b, 1 = a-b; sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  result; held until the next completion.
carry  output  1  carry out of the MSB; for sub, 1 = no borrow.
overflow  output  1  signed overflow of the last operation.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset: on a clk edge with reset=1, state goes to IDLE and busy, done, sum, carry, overflow, the internal shift registers, the carry flip-flop and the bit counter all clear to 0. Reset overrides all other inputs, including mid-RUN; the partial result is discarded and sum is not updated.
- States: IDLE, RUN, DONE. State is encoded in registers; busy = (state==RUN); done = (state==DONE).
- Start (IDLE or DONE, start=1 at edge E0):
  - Load sa<=a.
  - Load sb<= sub ? ~b : b.
  - Set cff<=sub.
  - Clear cnt<=0.
  - Go to RUN.
- In IDLE, start=0 keeps the block in IDLE.
- In RUN, start is ignored and the operands are not resampled.
- RUN edge, per bit:
  - Stage 1: h = sa[0]^sb[0], g = sa[0]&sb[0].
  - Stage 2: s = h^cff, co = g | (h&cff).
  - Shift the result register right, inserting s at the MSB.
  - Shift sa and sb right by one.
  - cff<=co.
  - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-2, latch cprev<=co (the carry into the MSB).
- Last bit: on the RUN edge where cnt==WIDTH-1, the block:
  - writes sum<=final shifted result;
  - sets carry<=co;
  - sets overflow<=co^cprev;
  - goes to DONE.
- Latency: the bit cycles occupy edges E1..EWIDTH. done=1 and the new sum/carry/overflow are visible in the cycle after edge E(WIDTH), i.e. WIDTH cycles after the start edge. busy is high for exactly WIDTH cycles.
- DONE lasts one cycle. With start=0 the next state is IDLE. With start=1 a new operation loads (back-to-back), and done deasserts on that edge.
- Outputs sum, carry and overflow change only at the last-bit edge or on reset.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - Subtraction is a + ~b + 1.
  - Overflow follows the two's-complement rule.
- The counter is ceil(log2(WIDTH)) bits wide and never wraps in normal operation.

Test Plan:
- WIDTH=8, reset=1 for 2 cycles -> busy=0, done=0, sum=0x00, carry=0, overflow=0.
- start, sub=0, a=0x05, b=0x03 -> busy high 8 cycles; done pulse exactly 8 cycles after the start edge; sum=0x08, carry=0, overflow=0.
- Add boundary cases:
  - a=0xFF, b=0x01 -> sum=0x00, carry=1, overflow=0.
  - a=0x7F, b=0x01 -> sum=0x80, carry=0, overflow=1.
- Subtract cases:
  - sub=1, a=0x05, b=0x03 -> sum=0x02, carry=1, overflow=0.
  - sub=1, a=0x03, b=0x05 -> sum=0xFE, carry=0, overflow=0.
  - sub=1, a=0x80, b=0x01 -> sum=0x7F, carry=1, overflow=1.
- start pulsed with different operands during RUN -> ignored; the original result appears on schedule.
- Back-to-back and reset mid-operation:
  - start held high in the DONE cycle with a=0x10, b=0x20 -> second done 8 cycles later, sum=0x30.
  - reset asserted at bit-cycle 4 -> next cycle IDLE with all outputs 0; the following start completes normally.
